// File: rtl/tl_ul_a_arbiter_if.sv
// TileLink-UL link (A and D channels) used for both requester and slave ports of tl_ul_a_arbiter.
// master = side that issues A requests and receives D responses; slave = the opposite side.
interface tl_ul_a_arbiter_if #(
  parameter int unsigned SRC_W = 2
);
  logic             a_valid;
  logic             a_ready;
  logic [2:0]       a_opcode;
  logic [2:0]       a_param;
  logic [2:0]       a_size;
  logic [SRC_W-1:0] a_source;
  logic [31:0]      a_address;
  logic [3:0]       a_mask;
  logic [31:0]      a_data;

  logic             d_valid;
  logic             d_ready;
  logic [2:0]       d_opcode;
  logic [1:0]       d_param;
  logic [2:0]       d_size;
  logic [SRC_W-1:0] d_source;
  logic             d_sink;
  logic             d_denied;
  logic             d_corrupt;
  logic [31:0]      d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    input  d_ready
  );
endinterface

// File: rtl/tl_ul_a_arbiter.sv
// Two-requester round-robin TileLink-UL A-channel arbiter with burst lock and D routing by source prefix.
// Optional per-requester inflight limit: define TL_ARB_INFLIGHT_LIMIT_EN.
module tl_ul_a_arbiter #(
  parameter int unsigned SRC_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic               clock,
  input  logic               reset,
  tl_ul_a_arbiter_if.slave   in0,
  tl_ul_a_arbiter_if.slave   in1,
  tl_ul_a_arbiter_if.master  out
);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lockState_e;

  lockState_e state, stateNext;
  logic       rrLast, rrLastNext;
  logic       grant;
  logic [5:0] aBeats, aBeatsNext;
  logic [5:0] dBeats, dBeatsNext;

  logic       elig0, elig1;
  logic       sel, selValid;
  logic [2:0] selOpcode, selSize;
  logic [5:0] msgBeatsM1, dBeatsM1;
  logic       aFire, aFirst;
  logic       dFire, dRoute, dLast;

  function automatic logic [5:0] beatsMinusOne(input logic [2:0] size);
    return (size > 3'd2) ? 6'((7'd1 << (size - 3'd2)) - 7'd1) : '0;
  endfunction

  // Lock covers both a stalled request (field stability) and the rest of a Put burst.
  always_comb begin
    sel      = grant;
    selValid = 1'b0;
    if (state == ST_LOCKED) begin
      sel      = grant;
      selValid = grant ? in1.a_valid : in0.a_valid;
    end else begin
      selValid = elig0 | elig1;
      sel      = (elig0 & elig1) ? ~rrLast : elig1;
    end
  end

  assign selOpcode     = sel ? in1.a_opcode : in0.a_opcode;
  assign selSize       = sel ? in1.a_size   : in0.a_size;

  assign out.a_valid   = selValid;
  assign out.a_opcode  = selOpcode;
  assign out.a_param   = sel ? in1.a_param   : in0.a_param;
  assign out.a_size    = selSize;
  assign out.a_source  = {sel, (sel ? in1.a_source : in0.a_source)};
  assign out.a_address = sel ? in1.a_address : in0.a_address;
  assign out.a_mask    = sel ? in1.a_mask    : in0.a_mask;
  assign out.a_data    = sel ? in1.a_data    : in0.a_data;

  assign in0.a_ready   = out.a_ready & selValid & ~sel;
  assign in1.a_ready   = out.a_ready & selValid &  sel;

  assign aFire      = selValid & out.a_ready;
  assign aFirst     = (aBeats == '0);
  assign msgBeatsM1 = (selOpcode == 3'd0 || selOpcode == 3'd1) ? beatsMinusOne(selSize) : '0;

  always_comb begin
    stateNext  = state;
    aBeatsNext = aBeats;
    rrLastNext = rrLast;
    if (aFire) begin
      if (aFirst) begin
        rrLastNext = sel;
        aBeatsNext = msgBeatsM1;
        stateNext  = (msgBeatsM1 != '0) ? ST_LOCKED : ST_OPEN;
      end else begin
        aBeatsNext = aBeats - 6'd1;
        if (aBeats == 6'd1) stateNext = ST_OPEN;
      end
    end else if (selValid) begin
      stateNext = ST_LOCKED;
    end
  end

  // D channel: pure wires, steered by the prefix bit the A side added.
  assign dRoute        = out.d_source[SRC_W];
  assign in0.d_valid   = out.d_valid & ~dRoute;
  assign in1.d_valid   = out.d_valid &  dRoute;
  assign out.d_ready   = dRoute ? in1.d_ready : in0.d_ready;

  assign in0.d_opcode  = out.d_opcode;
  assign in0.d_param   = out.d_param;
  assign in0.d_size    = out.d_size;
  assign in0.d_source  = out.d_source[SRC_W-1:0];
  assign in0.d_sink    = out.d_sink;
  assign in0.d_denied  = out.d_denied;
  assign in0.d_corrupt = out.d_corrupt;
  assign in0.d_data    = out.d_data;

  assign in1.d_opcode  = out.d_opcode;
  assign in1.d_param   = out.d_param;
  assign in1.d_size    = out.d_size;
  assign in1.d_source  = out.d_source[SRC_W-1:0];
  assign in1.d_sink    = out.d_sink;
  assign in1.d_denied  = out.d_denied;
  assign in1.d_corrupt = out.d_corrupt;
  assign in1.d_data    = out.d_data;

  assign dFire    = out.d_valid & out.d_ready;
  assign dBeatsM1 = beatsMinusOne(out.d_size);
  assign dLast    = (out.d_opcode != 3'd1) || (dBeats == dBeatsM1);

  always_comb begin
    dBeatsNext = dBeats;
    if (dFire && out.d_opcode == 3'd1) begin
      dBeatsNext = dLast ? '0 : dBeats + 6'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_OPEN;
      rrLast <= 1'b1;
      grant  <= 1'b0;
      aBeats <= '0;
      dBeats <= '0;
    end else begin
      state  <= stateNext;
      rrLast <= rrLastNext;
      grant  <= sel;
      aBeats <= aBeatsNext;
      dBeats <= dBeatsNext;
    end
  end

`ifdef TL_ARB_INFLIGHT_LIMIT_EN
  localparam int unsigned INFL_W = $clog2(MAX_INFLIGHT + 1);

  logic [INFL_W-1:0] infl0, infl1, infl0Next, infl1Next;
  logic              inc0, inc1, dec0, dec1;

  assign elig0 = in0.a_valid & (infl0 != INFL_W'(MAX_INFLIGHT));
  assign elig1 = in1.a_valid & (infl1 != INFL_W'(MAX_INFLIGHT));

  assign inc0 = aFire & aFirst & ~sel;
  assign inc1 = aFire & aFirst &  sel;
  assign dec0 = dFire & dLast  & ~dRoute;
  assign dec1 = dFire & dLast  &  dRoute;

  always_comb begin
    infl0Next = infl0;
    infl1Next = infl1;
    if (inc0 && !dec0)      infl0Next = infl0 + INFL_W'(1);
    else if (dec0 && !inc0) infl0Next = infl0 - INFL_W'(1);
    if (inc1 && !dec1)      infl1Next = infl1 + INFL_W'(1);
    else if (dec1 && !inc1) infl1Next = infl1 - INFL_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      infl0 <= '0;
      infl1 <= '0;
    end else begin
      infl0 <= infl0Next;
      infl1 <= infl1Next;
    end
  end
`else
  assign elig0 = in0.a_valid;
  assign elig1 = in1.a_valid;
`endif

endmodule

// File: tb/tb_tl_ul_a_arbiter.sv
// Self-checking bench for tl_ul_a_arbiter: directed scenarios plus randomized traffic against a queue-level model.
module tb_tl_ul_a_arbiter;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  tl_ul_a_arbiter_if #(.SRC_W(2)) in0 ();
  tl_ul_a_arbiter_if #(.SRC_W(2)) in1 ();
  tl_ul_a_arbiter_if #(.SRC_W(3)) out ();

  tl_ul_a_arbiter #(.SRC_W(2), .MAX_INFLIGHT(2)) dut (
    .clock (clock),
    .reset (reset),
    .in0   (in0),
    .in1   (in1),
    .out   (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic driveA(input int n, input logic v, input logic [2:0] op, input logic [2:0] sz,
                        input logic [1:0] src, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data);
    if (n == 0) begin
      in0.a_valid = v; in0.a_opcode = op; in0.a_param = 3'd0; in0.a_size = sz;
      in0.a_source = src; in0.a_address = addr; in0.a_mask = mask; in0.a_data = data;
    end else begin
      in1.a_valid = v; in1.a_opcode = op; in1.a_param = 3'd0; in1.a_size = sz;
      in1.a_source = src; in1.a_address = addr; in1.a_mask = mask; in1.a_data = data;
    end
  endtask

  task automatic idleAll();
    driveA(0, 1'b0, 3'd4, 3'd2, 2'd0, 32'h0, 4'h0, 32'h0);
    driveA(1, 1'b0, 3'd4, 3'd2, 2'd0, 32'h0, 4'h0, 32'h0);
    out.a_ready = 1'b0;
    out.d_valid = 1'b0; out.d_opcode = 3'd0; out.d_param = 2'd0; out.d_size = 3'd2;
    out.d_source = 3'd0; out.d_sink = 1'b0; out.d_denied = 1'b0; out.d_corrupt = 1'b0;
    out.d_data = 32'h0;
    in0.d_ready = 1'b0;
    in1.d_ready = 1'b0;
  endtask

  task automatic doReset();
    idleAll();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    #2;
    checks++;
    if (out.a_valid !== 1'b0) begin
      failures++; $display("FAIL reset_a_valid got=%0b exp=0", out.a_valid);
    end
    checks++;
    if (in0.d_valid !== 1'b0 || in1.d_valid !== 1'b0) begin
      failures++; $display("FAIL reset_d_valid got=%0b%0b exp=00", in1.d_valid, in0.d_valid);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] expSrc;
    doReset();
    for (int i = 0; i < 4; i++) begin
      driveA(0, 1'b1, 3'd4, 3'd2, 2'd2, 32'h1000, 4'hF, 32'h0);
      driveA(1, 1'b1, 3'd4, 3'd2, 2'd1, 32'h2000, 4'hF, 32'h0);
      out.a_ready = 1'b1;
      #2;
      expSrc = (i % 2 == 1) ? 3'b101 : 3'b010;
      checks++;
      if (out.a_source !== expSrc) begin
        failures++; $display("FAIL rr_source cycle=%0d got=%0h exp=%0h", i, out.a_source, expSrc);
      end
      tick();
    end
    idleAll();
  endtask

  task automatic test_burst();
    doReset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) driveA(0, 1'b1, 3'd0, 3'd4, 2'd3, 32'h100, 4'hF, 32'hA000_0000 + 32'(i));
      else       driveA(0, 1'b1, 3'd4, 3'd2, 2'd3, 32'h200, 4'hF, 32'h0);
      driveA(1, 1'b1, 3'd4, 3'd2, 2'd0, 32'h300, 4'hF, 32'h0);
      out.a_ready = 1'b1;
      #2;
      if (i < 4) begin
        checks++;
        if (out.a_source !== 3'b011 || out.a_data !== 32'hA000_0000 + 32'(i)) begin
          failures++;
          $display("FAIL burst_beat cycle=%0d got src=%0h data=%0h exp src=3 data=%0h",
                   i, out.a_source, out.a_data, 32'hA000_0000 + 32'(i));
        end
        checks++;
        if (in1.a_ready !== 1'b0) begin
          failures++; $display("FAIL burst_in1_ready cycle=%0d got=%0b exp=0", i, in1.a_ready);
        end
      end else begin
        checks++;
        if (out.a_source !== 3'b100 || in1.a_ready !== 1'b1 || in0.a_ready !== 1'b0) begin
          failures++;
          $display("FAIL burst_handover got src=%0h rdy1=%0b rdy0=%0b exp src=4 rdy1=1 rdy0=0",
                   out.a_source, in1.a_ready, in0.a_ready);
        end
      end
      tick();
    end
    idleAll();
  endtask

  task automatic test_stall();
    doReset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) driveA(1, 1'b1, 3'd4, 3'd2, 2'd3, 32'hCAFE_0000, 4'hF, 32'h0);
      else       driveA(1, 1'b0, 3'd4, 3'd2, 2'd0, 32'h0, 4'h0, 32'h0);
      driveA(0, (i >= 1), 3'd4, 3'd2, 2'd1, 32'h1111, 4'hF, 32'h0);
      out.a_ready = (i >= 3);
      #2;
      if (i < 4) begin
        checks++;
        if (out.a_valid !== 1'b1 || out.a_source !== 3'b111 || out.a_address !== 32'hCAFE_0000) begin
          failures++;
          $display("FAIL stall_hold cycle=%0d got v=%0b src=%0h addr=%0h exp v=1 src=7 addr=cafe0000",
                   i, out.a_valid, out.a_source, out.a_address);
        end
        checks++;
        if (in1.a_ready !== (i == 3) || in0.a_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_ready cycle=%0d got rdy1=%0b rdy0=%0b exp rdy1=%0b rdy0=0",
                   i, in1.a_ready, in0.a_ready, (i == 3));
        end
      end else begin
        checks++;
        if (out.a_source !== 3'b001) begin
          failures++; $display("FAIL stall_release got src=%0h exp=1", out.a_source);
        end
      end
      tick();
    end
    idleAll();
  endtask

  task automatic test_d_routing();
    logic expReady;
    idleAll();
    for (int i = 0; i < 3; i++) begin
      out.d_valid = 1'b1; out.d_opcode = 3'd1; out.d_size = 3'd3; out.d_source = 3'b101;
      out.d_data = 32'h5500 + 32'(i);
      expReady = (i != 1);
      in1.d_ready = expReady;
      in0.d_ready = ~expReady;
      #2;
      checks++;
      if (in1.d_valid !== 1'b1 || in0.d_valid !== 1'b0) begin
        failures++; $display("FAIL d_valid cycle=%0d got v1=%0b v0=%0b exp v1=1 v0=0", i, in1.d_valid, in0.d_valid);
      end
      checks++;
      if (in1.d_source !== 2'b01 || in1.d_data !== 32'h5500 + 32'(i)) begin
        failures++; $display("FAIL d_fields cycle=%0d got src=%0h data=%0h exp src=1", i, in1.d_source, in1.d_data);
      end
      checks++;
      if (out.d_ready !== expReady) begin
        failures++; $display("FAIL d_ready cycle=%0d got=%0b exp=%0b", i, out.d_ready, expReady);
      end
      tick();
    end
    idleAll();
  endtask

  task automatic test_reset_mid_burst();
    doReset();
    for (int i = 0; i < 3; i++) begin
      driveA(0, 1'b1, 3'd0, 3'd5, 2'd0, 32'h400, 4'hF, 32'(i));
      out.a_ready = 1'b1;
      if (i == 2) reset = 1'b1;
      #2;
      if (i < 2) begin
        checks++;
        if (out.a_source !== 3'b000 || out.a_data !== 32'(i)) begin
          failures++; $display("FAIL rst_burst_beat cycle=%0d got src=%0h data=%0h exp src=0 data=%0h",
                               i, out.a_source, out.a_data, i);
        end
      end
      tick();
    end
    reset = 1'b0;
    driveA(0, 1'b0, 3'd4, 3'd2, 2'd0, 32'h0, 4'h0, 32'h0);
    driveA(1, 1'b1, 3'd4, 3'd2, 2'd2, 32'h500, 4'hF, 32'h0);
    #2;
    checks++;
    if (out.a_valid !== 1'b1 || out.a_source !== 3'b110) begin
      failures++; $display("FAIL rst_unlocked got v=%0b src=%0h exp v=1 src=6", out.a_valid, out.a_source);
    end
    tick();
    driveA(0, 1'b1, 3'd4, 3'd2, 2'd1, 32'h600, 4'hF, 32'h0);
    #2;
    checks++;
    if (out.a_source !== 3'b001) begin
      failures++; $display("FAIL rst_contention got src=%0h exp=1", out.a_source);
    end
    tick();
    idleAll();
  endtask

`ifdef TL_ARB_INFLIGHT_LIMIT_EN
  task automatic test_inflight();
    doReset();
    for (int i = 0; i < 2; i++) begin
      driveA(0, 1'b1, 3'd4, 3'd2, 2'(i), 32'h700, 4'hF, 32'h0);
      out.a_ready = 1'b1;
      tick();
    end
    #2;
    checks++;
    if (out.a_valid !== 1'b0 || in0.a_ready !== 1'b0) begin
      failures++; $display("FAIL infl_block got v=%0b rdy0=%0b exp 0 0", out.a_valid, in0.a_ready);
    end
    tick();
    driveA(1, 1'b1, 3'd4, 3'd2, 2'd2, 32'h800, 4'hF, 32'h0);
    #2;
    checks++;
    if (out.a_source !== 3'b110) begin
      failures++; $display("FAIL infl_other got src=%0h exp=6", out.a_source);
    end
    tick();
    driveA(1, 1'b0, 3'd4, 3'd2, 2'd0, 32'h0, 4'h0, 32'h0);
    out.a_ready = 1'b0;
    out.d_valid = 1'b1; out.d_opcode = 3'd0; out.d_size = 3'd2; out.d_source = 3'b000;
    in0.d_ready = 1'b1;
    tick();
    out.d_valid = 1'b0;
    #2;
    checks++;
    if (out.a_valid !== 1'b1 || out.a_source[2] !== 1'b0) begin
      failures++; $display("FAIL infl_release got v=%0b src=%0h exp v=1 src=0xx", out.a_valid, out.a_source);
    end
    tick();
    idleAll();
  endtask
`endif

`ifndef TL_ARB_INFLIGHT_LIMIT_EN
  task automatic test_random();
    bit         act[2], v[2], hold[2];
    int         beats[2], idx[2];
    logic [2:0] op[2], sz[2];
    logic [1:0] src[2];
    logic [31:0] addr[2], data[2];
    logic [3:0] mask[2];
    int         owner, remaining, lastWinner, s;
    bit         ev, rdy, fired;
    logic [2:0] expSrc, dsrc;
    logic       dv, r0, r1;
    doReset();
    owner = -1; remaining = 0; lastWinner = 1;
    for (int n = 0; n < 2; n++) begin
      act[n] = 0; v[n] = 0; hold[n] = 0; beats[n] = 0; idx[n] = 0;
      op[n] = 0; sz[n] = 0; src[n] = 0; addr[n] = 0; data[n] = 0; mask[n] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!hold[n]) begin
          if (!act[n] && $urandom_range(0, 2) != 0) begin
            act[n] = 1; idx[n] = 0;
            case ($urandom_range(0, 2))
              0: op[n] = 3'd0;
              1: op[n] = 3'd1;
              default: op[n] = 3'd4;
            endcase
            sz[n]   = (op[n] <= 3'd1) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 6));
            beats[n] = (op[n] <= 3'd1 && sz[n] > 3'd2) ? (1 << (int'(sz[n]) - 2)) : 1;
            src[n]  = 2'($urandom_range(0, 3));
            addr[n] = $urandom;
          end
          v[n] = act[n] && ($urandom_range(0, 3) != 0);
          if (v[n]) begin
            data[n] = $urandom;
            mask[n] = 4'($urandom_range(0, 15));
          end
        end
        driveA(n, v[n], op[n], sz[n], src[n], addr[n], mask[n], data[n]);
      end
      rdy = ($urandom_range(0, 3) != 0);
      out.a_ready = rdy;
      dv   = 1'($urandom_range(0, 1));
      dsrc = 3'($urandom_range(0, 7));
      r0   = 1'($urandom_range(0, 1));
      r1   = 1'($urandom_range(0, 1));
      out.d_valid = dv; out.d_source = dsrc; out.d_opcode = 3'd0; out.d_size = 3'd2;
      out.d_data = $urandom;
      in0.d_ready = r0; in1.d_ready = r1;
      #2;
      if (owner >= 0) begin
        s = owner; ev = v[s];
      end else if (v[0] && v[1]) begin
        s = 1 - lastWinner; ev = 1;
      end else if (v[1]) begin
        s = 1; ev = 1;
      end else begin
        s = 0; ev = v[0];
      end
      checks++;
      if (out.a_valid !== ev) begin
        failures++; $display("FAIL rand_a_valid cycle=%0d got=%0b exp=%0b", cyc, out.a_valid, ev);
      end
      if (ev) begin
        expSrc = {1'(s), src[s]};
        checks++;
        if (out.a_source !== expSrc || out.a_data !== data[s] || out.a_opcode !== op[s] ||
            out.a_size !== sz[s] || out.a_mask !== mask[s] || out.a_address !== addr[s]) begin
          failures++;
          $display("FAIL rand_a_fields cycle=%0d got src=%0h data=%0h op=%0h exp src=%0h data=%0h op=%0h",
                   cyc, out.a_source, out.a_data, out.a_opcode, expSrc, data[s], op[s]);
        end
      end
      if (v[0]) begin
        checks++;
        if (in0.a_ready !== (rdy && ev && s == 0)) begin
          failures++; $display("FAIL rand_in0_ready cycle=%0d got=%0b exp=%0b", cyc, in0.a_ready, (rdy && ev && s == 0));
        end
      end
      if (v[1]) begin
        checks++;
        if (in1.a_ready !== (rdy && ev && s == 1)) begin
          failures++; $display("FAIL rand_in1_ready cycle=%0d got=%0b exp=%0b", cyc, in1.a_ready, (rdy && ev && s == 1));
        end
      end
      checks++;
      if (in0.d_valid !== (dv & ~dsrc[2]) || in1.d_valid !== (dv & dsrc[2]) ||
          out.d_ready !== (dsrc[2] ? r1 : r0) || in0.d_source !== dsrc[1:0]) begin
        failures++;
        $display("FAIL rand_d_route cycle=%0d got v0=%0b v1=%0b rdy=%0b exp v0=%0b v1=%0b rdy=%0b",
                 cyc, in0.d_valid, in1.d_valid, out.d_ready, (dv & ~dsrc[2]), (dv & dsrc[2]), (dsrc[2] ? r1 : r0));
      end
      fired = ev && rdy;
      if (fired) begin
        if (idx[s] == 0) begin
          lastWinner = s;
          remaining  = beats[s] - 1;
        end else begin
          remaining  = remaining - 1;
        end
        owner = (remaining > 0) ? s : -1;
        idx[s]++;
        if (idx[s] == beats[s]) act[s] = 0;
      end else if (ev) begin
        owner = s;
      end
      for (int n = 0; n < 2; n++) hold[n] = v[n] && !(fired && s == n);
      tick();
    end
    idleAll();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idleAll();
    #1;
    test_reset();
    test_round_robin();
    test_burst();
    test_stall();
    test_d_routing();
    test_reset_mid_burst();
`ifdef TL_ARB_INFLIGHT_LIMIT_EN
    test_inflight();
`else
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
